mem_map_controller: RTL and testbench

- Parametrised, region-decoding successor to the single-RAM memory controller.
- Owns the internal dual-port RAM plus a memory-mapped I/O block.
- CPU side: request/acknowledge handshake, region decode, instruction write-protect and fault flag.
- VGA side: dedicated read-only port with fixed 1-cycle latency into the text/glyph regions.

---
 rtl/mem_map_controller_if.sv | 25 ++
 rtl/mem_map_controller.sv | 169 ++++++++++++++++
 tb/tb_mem_map_controller.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_map_controller_if.sv
// CPU-side request/acknowledge bus of the memory-mapped controller.
// The master drives the request; the slave (controller) answers with ready/ack/rdata/err.
interface mem_map_controller_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_ack, cpu_rdata, cpu_err
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_ack, cpu_rdata, cpu_err
    );
endinterface

// File: rtl/mem_map_controller.sv
// Region-decoding memory controller: dual-port RAM, memory-mapped I/O channels,
// CPU request/ack port with write-protect faults and a read-only VGA port.
module mem_map_controller #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int SIZE_TEXT  = 8192,
    parameter int SIZE_GLYPH = 1024,
    parameter int SIZE_IO    = 128,
    parameter int SIZE_INSTR = 10240,
    parameter int SIZE_STACK = 10240,
    parameter int IO_CH      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_map_controller_if.slave     cpu,
    input  logic                    wp_instr,
    input  logic [ADDR_W-1:0]       vga_addr,
    output logic [DATA_W-1:0]       vga_data_out,
    input  logic [IO_CH*DATA_W-1:0] io_in,
    output logic [IO_CH*DATA_W-1:0] io_out,
    output logic [IO_CH-1:0]        io_out_stb
);

    localparam logic [31:0] GLYPH_BASE = 32'(SIZE_TEXT);
    localparam logic [31:0] IN_BASE    = GLYPH_BASE + 32'(SIZE_GLYPH);
    localparam logic [31:0] OUT_BASE   = IN_BASE + 32'(SIZE_IO);
    localparam logic [31:0] INSTR_BASE = OUT_BASE + 32'(SIZE_IO);
    localparam logic [31:0] STACK_BASE = INSTR_BASE + 32'(SIZE_INSTR);
    localparam logic [31:0] MAP_END    = STACK_BASE + 32'(SIZE_STACK);

    typedef enum logic [2:0] {
        R_TEXT, R_GLYPH, R_IN, R_OUT, R_INSTR, R_STACK, R_NONE
    } region_e;

    typedef enum logic {IDLE, ACCESS} state_e;

    function automatic region_e decode(input logic [ADDR_W-1:0] a);
        logic [31:0] x;
        x = 32'(a);
        if (x < GLYPH_BASE)      return R_TEXT;
        else if (x < IN_BASE)    return R_GLYPH;
        else if (x < OUT_BASE)   return R_IN;
        else if (x < INSTR_BASE) return R_OUT;
        else if (x < STACK_BASE) return R_INSTR;
        else if (x < MAP_END)    return R_STACK;
        else                     return R_NONE;
    endfunction

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    state_e                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    ack_q, ack_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [DATA_W-1:0]       vga_q, vga_d;
    logic [IO_CH*DATA_W-1:0] io_out_q, io_out_d;
    logic [IO_CH-1:0]        stb_q, stb_d;
    logic                    mem_we;
    region_e                 region;
    logic [31:0]             in_off;
    logic [31:0]             out_off;

    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        ack_d    = 1'b0;
        rdata_d  = '0;
        err_d    = 1'b0;
        io_out_d = io_out_q;
        stb_d    = '0;
        mem_we   = 1'b0;
        region   = decode(cpu.cpu_addr);
        in_off   = 32'(cpu.cpu_addr) - IN_BASE;
        out_off  = 32'(cpu.cpu_addr) - OUT_BASE;

        case (state_q)
            IDLE: begin
                if (cpu.cpu_req) begin
                    state_d = ACCESS;
                    ready_d = 1'b0;
                    ack_d   = 1'b1;
                    case (region)
                        R_TEXT, R_GLYPH, R_STACK: begin
                            if (cpu.cpu_we) mem_we  = 1'b1;
                            else            rdata_d = mem[cpu.cpu_addr];
                        end
                        R_INSTR: begin
                            if (!cpu.cpu_we)  rdata_d = mem[cpu.cpu_addr];
                            else if (wp_instr) err_d  = 1'b1;
                            else               mem_we = 1'b1;
                        end
                        R_IN: begin
                            if (cpu.cpu_we) begin
                                err_d = 1'b1;
                            end else begin
                                for (int ch = 0; ch < IO_CH; ch++)
                                    if (in_off == 32'(ch)) rdata_d = io_in[ch*DATA_W +: DATA_W];
                            end
                        end
                        R_OUT: begin
                            // Offsets beyond the implemented channels read 0 and drop writes.
                            for (int ch = 0; ch < IO_CH; ch++) begin
                                if (out_off == 32'(ch)) begin
                                    if (cpu.cpu_we) begin
                                        io_out_d[ch*DATA_W +: DATA_W] = cpu.cpu_wdata;
                                        stb_d[ch] = 1'b1;
                                    end else begin
                                        rdata_d = io_out_q[ch*DATA_W +: DATA_W];
                                    end
                                end
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ACCESS: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // Only TEXT/GLYPH are visible to the display; the RAM read sees pre-write data.
    always_comb begin
        vga_d = '0;
        if (32'(vga_addr) < IN_BASE) vga_d = mem[vga_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            vga_q    <= '0;
            io_out_q <= '0;
            stb_q    <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            vga_q    <= vga_d;
            io_out_q <= io_out_d;
            stb_q    <= stb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && reset) mem[cpu.cpu_addr] <= cpu.cpu_wdata;
    end

    assign cpu.cpu_ready = ready_q;
    assign cpu.cpu_ack   = ack_q;
    assign cpu.cpu_rdata = rdata_q;
    assign cpu.cpu_err   = err_q;
    assign vga_data_out  = vga_q;
    assign io_out        = io_out_q;
    assign io_out_stb    = stb_q;

endmodule

// File: tb/tb_mem_map_controller.sv
// Bench for mem_map_controller: directed vector table, hand-written multi-cycle
// sequences, and randomized accesses against an address-map reference model.
module tb_mem_map_controller;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int IO_CH  = 8;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    wp_instr;
    logic [ADDR_W-1:0]       vga_addr;
    logic [DATA_W-1:0]       vga_data_out;
    logic [IO_CH*DATA_W-1:0] io_in;
    logic [IO_CH*DATA_W-1:0] io_out;
    logic [IO_CH-1:0]        io_out_stb;

    mem_map_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_map_controller #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_TEXT(8192), .SIZE_GLYPH(1024),
        .SIZE_IO(128), .SIZE_INSTR(10240), .SIZE_STACK(10240), .IO_CH(IO_CH)
    ) dut (
        .clk(clk), .reset(reset), .cpu(bus), .wp_instr(wp_instr),
        .vga_addr(vga_addr), .vga_data_out(vga_data_out),
        .io_in(io_in), .io_out(io_out), .io_out_stb(io_out_stb)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: address map taken straight from the decode table.
    logic [15:0] ram_m [int];
    logic [15:0] io_m [8];

    function automatic int region_of(input int a);
        if (a < 'h2000) return 0;
        if (a < 'h2400) return 1;
        if (a < 'h2480) return 2;
        if (a < 'h2500) return 3;
        if (a < 'h4D00) return 4;
        if (a < 'h7500) return 5;
        return 6;
    endfunction

    task automatic model(input logic we, input logic [14:0] addr, input logic [15:0] wd,
                         input logic wp, input logic [127:0] inv,
                         output logic [15:0] rd, output logic er, output logic [7:0] stb,
                         output logic known);
        int a, r, k;
        a = int'(addr);
        r = region_of(a);
        rd = '0; er = 1'b0; stb = '0; known = 1'b1;
        if (r == 6) begin
            er = 1'b1;
        end else if (r == 2) begin
            k = a - 'h2400;
            if (we) er = 1'b1;
            else if (k < 8) rd = inv[k*16 +: 16];
        end else if (r == 3) begin
            k = a - 'h2480;
            if (k < 8) begin
                if (we) begin io_m[k] = wd; stb[k] = 1'b1; end
                else rd = io_m[k];
            end
        end else begin
            if (we) begin
                if (r == 4 && wp) er = 1'b1;
                else ram_m[a] = wd;
            end else if (ram_m.exists(a)) rd = ram_m[a];
            else known = 1'b0;
        end
    endtask

    function automatic logic [15:0] vga_model(input logic [14:0] va);
        int a;
        a = int'(va);
        if (a < 'h2400 && ram_m.exists(a)) return ram_m[a];
        return 16'h0000;
    endfunction

    function automatic logic [127:0] io_pack();
        logic [127:0] v;
        for (int k = 0; k < 8; k++) v[k*16 +: 16] = io_m[k];
        return v;
    endfunction

    // One CPU access; returns what the bus showed on the cycle after acceptance.
    task automatic access(input logic we, input logic [14:0] addr, input logic [15:0] wd,
                          input logic wp, output logic [15:0] rd, output logic er,
                          output logic ok);
        int n;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
        bus.cpu_wdata = wd; wp_instr = wp;
        n = 0;
        while (bus.cpu_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        ok = bus.cpu_ack; rd = bus.cpu_rdata; er = bus.cpu_err;
        bus.cpu_req = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [15:0] wd;
        logic        wp;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [23];

    logic [14:0] pool [26];

    logic [15:0]  rd, m_rd, exp_vga;
    logic         er, ok, m_er, known;
    logic [7:0]   m_stb;
    logic [127:0] rin;
    int           acks;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 15'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 15'h0010, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0};
        tbl[2]  = '{1'b1, 15'h2500, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{1'b1, 15'h2500, 16'h5555, 1'b1, 1'b1, 16'h0000, 1'b1};
        tbl[4]  = '{1'b0, 15'h2500, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 1'b0};
        tbl[5]  = '{1'b1, 15'h2500, 16'h5555, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[6]  = '{1'b0, 15'h2500, 16'h0000, 1'b0, 1'b1, 16'h5555, 1'b0};
        tbl[7]  = '{1'b0, 15'h7500, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
        tbl[8]  = '{1'b1, 15'h2400, 16'h1111, 1'b0, 1'b1, 16'h0000, 1'b1};
        tbl[9]  = '{1'b1, 15'h2482, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 15'h2482, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0};
        tbl[11] = '{1'b0, 15'h2405, 16'h0000, 1'b0, 1'b1, 16'h00A5, 1'b0};
        tbl[12] = '{1'b0, 15'h2408, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0};
        tbl[13] = '{1'b1, 15'h2490, 16'h9999, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[14] = '{1'b1, 15'h4D00, 16'hCAFE, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[15] = '{1'b0, 15'h4D00, 16'h0000, 1'b0, 1'b1, 16'hCAFE, 1'b0};
        tbl[16] = '{1'b1, 15'h23FF, 16'h0F0F, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[17] = '{1'b0, 15'h23FF, 16'h0000, 1'b0, 1'b1, 16'h0F0F, 1'b0};
        tbl[18] = '{1'b0, 15'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
        tbl[19] = '{1'b1, 15'h7500, 16'h2222, 1'b0, 1'b1, 16'h0000, 1'b1};
        tbl[20] = '{1'b1, 15'h74FF, 16'h1357, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[21] = '{1'b0, 15'h74FF, 16'h0000, 1'b0, 1'b1, 16'h1357, 1'b0};
        tbl[22] = '{1'b0, 15'h2500, 16'h0000, 1'b1, 1'b1, 16'h5555, 1'b0};

        pool = '{15'h0000, 15'h0010, 15'h1FFF, 15'h0555, 15'h2000, 15'h23FF, 15'h2123,
                 15'h2400, 15'h2405, 15'h2407, 15'h2408, 15'h247F,
                 15'h2480, 15'h2482, 15'h2487, 15'h2488, 15'h24FF,
                 15'h2500, 15'h3000, 15'h4CFF, 15'h4D00, 15'h6000, 15'h74FF,
                 15'h7500, 15'h7FFF, 15'h7A00};

        for (int k = 0; k < 8; k++) io_m[k] = '0;

        reset = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        wp_instr = 1'b0; vga_addr = '0; io_in = '0;
        io_in[5*16 +: 16] = 16'h00A5;

        #22;
        chk("reset_ready", bus.cpu_ready, 1'b1);
        chk("reset_ack", bus.cpu_ack, 1'b0);
        chk("reset_rdata", bus.cpu_rdata, 16'h0000);
        chk("reset_err", bus.cpu_err, 1'b0);
        chk("reset_vga", vga_data_out, 16'h0000);
        chk("reset_io_out", io_out, 128'h0);
        chk("reset_stb", io_out_stb, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.cpu_ack) acks++;
        end
        chk("no_spurious_ack", 32'(acks), 32'd0);

        for (int i = 0; i < 23; i++) begin
            model(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].wp, io_in, m_rd, m_er, m_stb, known);
            access(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].wp, rd, er, ok);
            chk($sformatf("vec%0d_ack", i), ok, 1'b1);
            chk($sformatf("vec%0d_err", i), er, tbl[i].exp_err);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
        end
        chk("io_out_ch2", io_out, 128'h0000_0000_0000_0000_0000_1234_0000_0000);

        // VGA reads: TEXT hit, INSTR gives 0.
        @(negedge clk); vga_addr = 15'h0010;
        @(negedge clk); chk("vga_text", vga_data_out, 16'hBEEF);
        vga_addr = 15'h2500;
        @(negedge clk); chk("vga_instr_zero", vga_data_out, 16'h0000);

        // Output strobe lasts exactly one cycle.
        model(1'b1, 15'h2482, 16'h1234, 1'b0, io_in, m_rd, m_er, m_stb, known);
        access(1'b1, 15'h2482, 16'h1234, 1'b0, rd, er, ok);
        chk("stb_pulse", io_out_stb, 8'b0000_0100);
        @(negedge clk);
        chk("stb_clear", io_out_stb, 8'b0000_0000);

        // Request held for 6 cycles yields 3 acks.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'h0010;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.cpu_ack) acks++;
        end
        bus.cpu_req = 1'b0;
        chk("hold_req_acks", 32'(acks), 32'd3);
        @(negedge clk);
        chk("hold_req_done", bus.cpu_ack, 1'b0);

        // Reset during ACCESS: ack suppressed, io_out cleared, RAM write stands.
        model(1'b1, 15'h2483, 16'h7777, 1'b0, io_in, m_rd, m_er, m_stb, known);
        access(1'b1, 15'h2483, 16'h7777, 1'b0, rd, er, ok);
        chk("io_out_ch3", io_out[3*16 +: 16], 16'h7777);
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'h0020; bus.cpu_wdata = 16'h4242;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midreset_ack", bus.cpu_ack, 1'b0);
        chk("midreset_io_out", io_out, 128'h0);
        chk("midreset_ready", bus.cpu_ready, 1'b1);
        @(negedge clk); bus.cpu_req = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); chk("postreset_ack", bus.cpu_ack, 1'b0);
        ram_m[32'h20] = 16'h4242;
        for (int k = 0; k < 8; k++) io_m[k] = '0;
        access(1'b0, 15'h0020, 16'h0000, 1'b0, rd, er, ok);
        chk("midreset_ram_kept", rd, 16'h4242);

        // Give every RAM address in the pool a known value.
        for (int i = 0; i < 26; i++) begin
            if (region_of(int'(pool[i])) inside {0, 1, 4, 5}) begin
                rin = {$urandom, $urandom, $urandom, $urandom};
                model(1'b1, pool[i], 16'($urandom), 1'b0, rin, m_rd, m_er, m_stb, known);
                access(1'b1, pool[i], ram_m[int'(pool[i])], 1'b0, rd, er, ok);
            end
        end

        for (int i = 0; i < 300; i++) begin
            logic        we, wp;
            logic [14:0] addr;
            logic [15:0] wd;
            we   = 1'($urandom_range(0, 1));
            wp   = 1'($urandom_range(0, 1));
            addr = pool[$urandom_range(0, 25)];
            wd   = 16'($urandom);
            rin  = {$urandom, $urandom, $urandom, $urandom};
            io_in = rin;
            vga_addr = ($urandom_range(0, 3) == 0) ? addr : pool[$urandom_range(0, 25)];
            exp_vga = vga_model(vga_addr);
            model(we, addr, wd, wp, rin, m_rd, m_er, m_stb, known);
            access(we, addr, wd, wp, rd, er, ok);
            chk($sformatf("rnd%0d_ack", i), ok, 1'b1);
            chk($sformatf("rnd%0d_err", i), er, m_er);
            if ((!we || m_er) && known) chk($sformatf("rnd%0d_rdata", i), rd, m_rd);
            chk($sformatf("rnd%0d_stb", i), io_out_stb, m_stb);
            chk($sformatf("rnd%0d_io_out", i), io_out, io_pack());
            chk($sformatf("rnd%0d_vga", i), vga_data_out, exp_vga);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
